fft_bitrev_reorder: RTL and testbench

Output reorder stage placed directly downstream of the radix-2^2 SDF FFT pipeline. It takes the FFT's serial complex output stream, which arrives in bit-reversed index order, and re-emits each N-point frame in natural index order. It uses a ping-pong pair of N-entry banks so that a continuous input stream produces a continuous output stream. It also adds frame markers and a natural-order index for downstream CNN/feature logic.

---
 rtl/fft_bitrev_reorder.sv | 142 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - bit-reversed to natural order FFT output reorder
// Ping-pong banks: the writer scatters by bitrev(count), the reader sweeps addresses linearly.
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_val,
  input  logic [DATA_WIDTH-1:0]         in_re,
  input  logic [DATA_WIDTH-1:0]         in_im,
  output logic                          out_val,
  output logic [DATA_WIDTH-1:0]         out_re,
  output logic [DATA_WIDTH-1:0]         out_im,
  output logic [$clog2(N_POINTS)-1:0]   out_idx,
  output logic                          out_sof,
  output logic                          out_eof
);

  localparam int AW = $clog2(N_POINTS);
  localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

  generate
    if (N_POINTS < 4 || (N_POINTS & (N_POINTS - 1)) != 0) begin : g_bad_n
      $error("N_POINTS must be a power of two and at least 4");
    end
  endgenerate

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
    return r;
  endfunction

  logic [2*DATA_WIDTH-1:0] bank0 [N_POINTS];
  logic [2*DATA_WIDTH-1:0] bank1 [N_POINTS];

  logic [AW-1:0]           wcnt_q;
  logic                    wbank_q;
  logic [1:0]              full_q;
  state_t                  state_q;
  logic                    rbank_q;
  logic [AW-1:0]           raddr_q;
  logic                    out_val_q;
  logic [2*DATA_WIDTH-1:0] out_data_q;
  logic [AW-1:0]           out_idx_q;
  logic                    out_sof_q;
  logic                    out_eof_q;

  logic                    accept;
  logic                    wr_last;
  logic                    rd_last;
  logic [1:0]              full_set;
  logic [1:0]              full_clr;
  logic [1:0]              full_avail;
  logic [2*DATA_WIDTH-1:0] rd_word;

  assign accept   = en & in_val;
  assign wr_last  = accept && (wcnt_q == LAST);
  assign rd_last  = (state_q == READ) && (raddr_q == LAST);
  assign full_set = wr_last ? (2'b01 << wbank_q) : 2'b00;
  assign full_clr = rd_last ? (2'b01 << rbank_q) : 2'b00;
  // A frame completing this cycle is visible to the reader now, so there is no bubble.
  assign full_avail = full_q | full_set;
  assign rd_word    = rbank_q ? bank1[raddr_q] : bank0[raddr_q];

  always_ff @(posedge clk) begin
    if (accept) begin
      if (wbank_q) bank1[bitrev(wcnt_q)] <= {in_re, in_im};
      else         bank0[bitrev(wcnt_q)] <= {in_re, in_im};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      full_q  <= 2'b00;
    end else begin
      if (accept) wcnt_q <= wcnt_q + 1'b1;
      if (wr_last) wbank_q <= ~wbank_q;
      full_q <= (full_q | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rbank_q    <= 1'b0;
      raddr_q    <= '0;
      out_val_q  <= 1'b0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_sof_q  <= 1'b0;
      out_eof_q  <= 1'b0;
    end else begin
      out_val_q <= (state_q == READ);
      if (state_q == READ) begin
        out_data_q <= rd_word;
        out_idx_q  <= raddr_q;
        out_sof_q  <= (raddr_q == '0);
        out_eof_q  <= (raddr_q == LAST);
      end else begin
        out_sof_q  <= 1'b0;
        out_eof_q  <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          raddr_q <= '0;
          if (full_avail[0]) begin
            state_q <= READ;
            rbank_q <= 1'b0;
          end else if (full_avail[1]) begin
            state_q <= READ;
            rbank_q <= 1'b1;
          end
        end
        READ: begin
          if (raddr_q == LAST) begin
            raddr_q <= '0;
            if (full_avail[~rbank_q]) rbank_q <= ~rbank_q;
            else                      state_q <= IDLE;
          end else begin
            raddr_q <= raddr_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_val = out_val_q;
  assign out_re  = out_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_im  = out_data_q[DATA_WIDTH-1:0];
  assign out_idx = out_idx_q;
  assign out_sof = out_sof_q;
  assign out_eof = out_eof_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - scoreboard bench for fft_bitrev_reorder (N=16 and N=64 instances)
module tb_fft_bitrev_reorder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en0 = 1'b0, v0 = 1'b0;
  logic [15:0] re0 = '0, im0 = '0;
  logic        ov0, osof0, oeof0;
  logic [15:0] ore0, oim0;
  logic [3:0]  oidx0;

  logic        en1 = 1'b0, v1 = 1'b0;
  logic [11:0] re1 = '0, im1 = '0;
  logic        ov1, osof1, oeof1;
  logic [11:0] ore1, oim1;
  logic [5:0]  oidx1;

  fft_bitrev_reorder #(.DATA_WIDTH(16), .N_POINTS(16)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .in_val(v0), .in_re(re0), .in_im(im0),
    .out_val(ov0), .out_re(ore0), .out_im(oim0), .out_idx(oidx0),
    .out_sof(osof0), .out_eof(oeof0));

  fft_bitrev_reorder #(.DATA_WIDTH(12), .N_POINTS(64)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .in_val(v1), .in_re(re1), .in_im(im1),
    .out_val(ov1), .out_re(ore1), .out_im(oim1), .out_idx(oidx1),
    .out_sof(osof1), .out_eof(oeof1));

  typedef struct { int re; int im; int idx; } exp_t;
  exp_t q0[$], q1[$];
  int p0re[$], p0im[$], p1re[$], p1im[$];
  int total = 0, bad = 0;
  int cnt0 = 0, cnt1 = 0, run0 = 0, maxrun0 = 0, sofcnt0 = 0;
  int cap0 [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int rev(input int i, input int bits);
    int r = 0;
    int x = i;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Reference: collect a frame in arrival order; natural index i holds arrival bitrev(i).
  task automatic push_sample(input int d, input int re, input int im);
    exp_t e;
    if (d == 0) begin
      p0re.push_back(re); p0im.push_back(im);
      if (p0re.size() == 16) begin
        for (int i = 0; i < 16; i++) begin
          e.re = p0re[rev(i, 4)]; e.im = p0im[rev(i, 4)]; e.idx = i;
          q0.push_back(e);
        end
        p0re.delete(); p0im.delete();
      end
    end else begin
      p1re.push_back(re); p1im.push_back(im);
      if (p1re.size() == 64) begin
        for (int i = 0; i < 64; i++) begin
          e.re = p1re[rev(i, 6)]; e.im = p1im[rev(i, 6)]; e.idx = i;
          q1.push_back(e);
        end
        p1re.delete(); p1im.delete();
      end
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst) begin
      if (ov0) begin
        cnt0++; run0++;
        if (run0 > maxrun0) maxrun0 = run0;
        if (osof0) sofcnt0++;
        if (q0.size() == 0) chk("d0_spurious_val", 64'(ov0), 64'd0);
        else begin
          e = q0.pop_front();
          chk("d0_re",  64'(ore0),  64'(e.re));
          chk("d0_im",  64'(oim0),  64'(e.im));
          chk("d0_idx", 64'(oidx0), 64'(e.idx));
          chk("d0_sof", 64'(osof0), 64'(e.idx == 0));
          chk("d0_eof", 64'(oeof0), 64'(e.idx == 15));
          cap0[oidx0] = int'(ore0);
        end
      end else run0 = 0;
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && ov1) begin
      cnt1++;
      if (q1.size() == 0) chk("d1_spurious_val", 64'(ov1), 64'd0);
      else begin
        e = q1.pop_front();
        chk("d1_re",  64'(ore1),  64'(e.re));
        chk("d1_im",  64'(oim1),  64'(e.im));
        chk("d1_idx", 64'(oidx1), 64'(e.idx));
        chk("d1_sof", 64'(osof1), 64'(e.idx == 0));
        chk("d1_eof", 64'(oeof1), 64'(e.idx == 63));
      end
    end
  end

  task automatic drv0(input bit v, input bit e, input int re, input int im);
    v0 = v; en0 = e; re0 = re[15:0]; im0 = im[15:0];
    if (v && e) push_sample(0, re & 16'hffff, im & 16'hffff);
    @(negedge clk);
  endtask

  task automatic drv1(input bit v, input bit e, input int re, input int im);
    v1 = v; en1 = e; re1 = re[11:0]; im1 = im[11:0];
    if (v && e) push_sample(1, re & 12'hfff, im & 12'hfff);
    @(negedge clk);
  endtask

  task automatic drain(input int d);
    int i = 0;
    while (((d == 0) ? (q0.size() != 0 || ov0) : (q1.size() != 0 || ov1)) && i < 400) begin
      @(negedge clk);
      i++;
    end
    chk("drain_left", 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 16; i++) cap0[i] = -1;
  endtask

  task automatic spot_check(input string tag);
    chk({tag, "_idx1"},  64'(cap0[1]),  64'd8);
    chk({tag, "_idx3"},  64'(cap0[3]),  64'd12);
    chk({tag, "_idx15"}, 64'(cap0[15]), 64'd15);
    chk({tag, "_idx0"},  64'(cap0[0]),  64'd0);
  endtask

  task automatic latency_check(input string tag);
    v0 = 1'b0;
    chk({tag, "_val_early"}, 64'(ov0), 64'd0);
    @(negedge clk);
    chk({tag, "_val_at_2"}, 64'(ov0), 64'd1);
    chk({tag, "_sof_at_2"}, 64'(osof0), 64'd1);
  endtask

  int c, s, found;

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_val", 64'(ov0), 64'd0);
    chk("rst_re",  64'(ore0), 64'd0);
    chk("rst_im",  64'(oim0), 64'd0);
    chk("rst_idx", 64'(oidx0), 64'd0);
    chk("rst_sof", 64'(osof0), 64'd0);
    chk("rst_eof", 64'(oeof0), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single frame, arrival k carries re=k
    clear_cap();
    for (int k = 0; k < 16; k++) drv0(1, 1, k, ~k);
    latency_check("t1");
    drain(0);
    spot_check("t1");

    // Test 2: four frames back to back
    repeat (3) @(negedge clk);
    maxrun0 = 0; s = sofcnt0;
    for (int k = 0; k < 64; k++) drv0(1, 1, $urandom, $urandom);
    v0 = 1'b0;
    drain(0);
    chk("t2_no_bubble", 64'(maxrun0), 64'd64);
    chk("t2_sof_count", 64'(sofcnt0 - s), 64'd4);

    // Test 3: gaps and en low with in_val high
    clear_cap();
    for (int k = 0; k < 16; k++) begin
      if (k > 0) drv0(0, 1, 16'hdead, 16'hbeef);
      if (k == 8) repeat (3) drv0(1, 0, 16'hbad0, 16'hbad1);
      drv0(1, 1, k, ~k);
    end
    latency_check("t3");
    drain(0);
    spot_check("t3");

    // Test 4: partial frame must stay silent
    c = cnt0;
    for (int k = 0; k < 10; k++) drv0(1, 1, $urandom, $urandom);
    v0 = 1'b0;
    repeat (50) @(negedge clk);
    chk("t4_partial_silent", 64'(cnt0 - c), 64'd0);
    for (int k = 0; k < 6; k++) drv0(1, 1, $urandom, $urandom);
    v0 = 1'b0;
    drain(0);
    chk("t4_frame_count", 64'(cnt0 - c), 64'd16);

    // Test 5: reset while reading idx 5 with a half-written second frame
    for (int k = 0; k < 16; k++) drv0(1, 1, 100 + k, 500 + k);
    for (int k = 0; k < 6; k++)  drv0(1, 1, 200 + k, 600 + k);
    v0 = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (ov0 && oidx0 == 4'd5) found = 1;
      else @(negedge clk);
    end
    chk("t5_reached_idx5", 64'(found), 64'd1);
    #2 rst = 1'b1;
    q0.delete(); p0re.delete(); p0im.delete();
    #1;
    chk("t5_rst_val", 64'(ov0), 64'd0);
    chk("t5_rst_re",  64'(ore0), 64'd0);
    chk("t5_rst_im",  64'(oim0), 64'd0);
    chk("t5_rst_idx", 64'(oidx0), 64'd0);
    chk("t5_rst_sof", 64'(osof0), 64'd0);
    chk("t5_rst_eof", 64'(oeof0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c = cnt0;
    for (int k = 0; k < 16; k++) drv0(1, 1, 300 + k, 700 + k);
    v0 = 1'b0;
    drain(0);
    chk("t5_fresh_count", 64'(cnt0 - c), 64'd16);

    // Test 6: N=64, 12-bit, random data and gaps
    c = cnt1;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 64; k++) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 0) drv1(0, 1, $urandom, $urandom);
          else                           drv1(1, 0, $urandom, $urandom);
        end
        drv1(1, 1, $urandom, $urandom);
      end
    end
    v1 = 1'b0;
    drain(1);
    chk("t6_frame_count", 64'(cnt1 - c), 64'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
